// File: rtl/link_pkg.sv
// Shared types and helpers for the soft-symbol link: beat count, bit-to-symbol map, saturating add.
// Pure definitions; no state, no timing.
package link_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    function automatic int beats(input int data_w, input int lanes);
        return data_w / lanes;
    endfunction

    // Antipodal map: 1 -> +amp, 0 -> -amp.
    function automatic int map_bit(input logic b, input int amp);
        return b ? amp : -amp;
    endfunction

    // Adds two values and clamps the result to the signed range of a w-bit word.
    function automatic int sat_add(input int a, input int b, input int w);
        int s;
        int hi;
        int lo;
        s  = a + b;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/sym_lane.sv
// One lane: map bit to +/-AMP, add shared noise with saturation, register, slice by sign.
// One-cycle latency from tx_bit/noise to sym_obs; rx_bit is combinational from sym_obs.
module sym_lane
    import link_pkg::*;
#(
    parameter int SYM_W   = 9,
    parameter int NOISE_W = 7,
    parameter int AMP     = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tx_bit,
    input  logic signed [NOISE_W-1:0] noise,
    output logic [SYM_W-1:0]          sym_obs,
    output logic                      rx_bit
);

    int noisy;

    always_comb begin
        noisy = sat_add(map_bit(tx_bit, AMP), int'(noise), SYM_W);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sym_obs <= '0;
        end else begin
            sym_obs <= noisy[SYM_W-1:0];
        end
    end

    // Non-negative (including zero) slices to 1.
    assign rx_bit = ~sym_obs[SYM_W-1];

endmodule

// File: rtl/soft_bit_link.sv
// Serialise words into antipodal soft symbols, add noise, slice, reassemble and count bit errors.
// out_valid pulses 4 edges after acceptance (BEATS=3); in_ready drops mid-word, back-to-back at one word per BEATS cycles.
module soft_bit_link
    import link_pkg::*;
#(
    parameter int DATA_W  = 12,
    parameter int LANES   = 4,
    parameter int SYM_W   = 9,
    parameter int NOISE_W = 7,
    parameter int AMP     = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [NOISE_W-1:0] noise,
    output logic [LANES*SYM_W-1:0]    sym_obs,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    output logic [15:0]               err_count
);

    localparam int BEATS_N = beats(DATA_W, LANES);
    localparam int BW      = (BEATS_N > 1) ? $clog2(BEATS_N) : 1;
    localparam int PW      = $clog2(LANES + 1);
    localparam logic [BW-1:0] LAST = BW'(BEATS_N - 1);

    tx_state_t         state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              tx_vld;
    logic [LANES-1:0]  tx_bits;
    logic [LANES-1:0]  rx_bits;

    logic              s1_vld;
    logic [BW-1:0]     s1_beat;
    logic [LANES-1:0]  s1_sent;

    logic [DATA_W-1:0] asm_q, asm_d;
    logic [PW-1:0]     pop;
    logic [16:0]       err_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        word_d   = word_q;
        in_ready = 1'b0;
        tx_vld   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_d  = in_data;
                    beat_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_vld = 1'b1;
                if (beat_q == LAST) begin
                    // Last beat can overlap with the next acceptance, so no bubble.
                    in_ready = 1'b1;
                    if (in_valid) begin
                        word_d = in_data;
                        beat_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_bits = word_q[int'(beat_q)*LANES +: LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sym_lane #(
            .SYM_W  (SYM_W),
            .NOISE_W(NOISE_W),
            .AMP    (AMP)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .tx_bit (tx_bits[i]),
            .noise  (noise),
            .sym_obs(sym_obs[i*SYM_W +: SYM_W]),
            .rx_bit (rx_bits[i])
        );
    end

    // Sent bits and beat index ride alongside the channel register so overlapping words stay separate.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_beat <= '0;
            s1_sent <= '0;
        end else begin
            s1_vld  <= tx_vld;
            s1_beat <= beat_q;
            s1_sent <= tx_bits;
        end
    end

    always_comb begin
        asm_d = asm_q;
        asm_d[int'(s1_beat)*LANES +: LANES] = rx_bits;
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + PW'(rx_bits[i] ^ s1_sent[i]);
        end
        err_sum = 17'(err_count) + 17'(pop);
    end

    // Assembly register keeps out_data stable while the next word is being collected.
    always_ff @(posedge clk) begin
        if (reset) begin
            asm_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            err_count <= '0;
        end else begin
            out_valid <= 1'b0;
            if (s1_vld) begin
                asm_q     <= asm_d;
                err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
                if (s1_beat == LAST) begin
                    out_data  <= asm_d;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_soft_bit_link.sv
// Scoreboarded bench: two instances (9-bit symbols with 8-bit noise, and 8-bit symbols at AMP=127 for saturation).
module tb_soft_bit_link;

    logic               clk = 1'b0;
    logic               reset;
    logic [11:0]        in_data;
    logic               in_valid;
    logic               in_ready, in_ready2;
    logic signed [7:0]  noise;
    logic signed [6:0]  noise2;
    logic [35:0]        sym_obs;
    logic [31:0]        sym_obs2;
    logic [11:0]        out_data, out_data2;
    logic               out_valid, out_valid2;
    logic [15:0]        err_count, err_count2;

    typedef struct {
        logic [11:0] data;
        logic [15:0] err;
        int          e0;
    } exp_t;

    exp_t q[$];
    exp_t q2[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   exp_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    soft_bit_link #(.NOISE_W(8)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .noise(noise), .sym_obs(sym_obs), .out_data(out_data), .out_valid(out_valid),
        .err_count(err_count)
    );

    soft_bit_link #(.SYM_W(8), .AMP(127)) dut2 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
        .noise(noise2), .sym_obs(sym_obs2), .out_data(out_data2), .out_valid(out_valid2),
        .err_count(err_count2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("out_data", out_data, e.data);
                chk("err_count", err_count, e.err);
                chk("latency", cyc, e.e0 + 4);
            end
        end
        if (out_valid2) begin
            if (q2.size() == 0) begin
                chk("unexpected_out_valid2", 1, 0);
            end else begin
                e = q2.pop_front();
                chk("out_data2", out_data2, e.data);
                chk("latency2", cyc, e.e0 + 4);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [11:0] d, input logic [11:0] exp_d, input int nerr,
                        input bit keep, output int e0);
        int n;
        exp_t e;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            e0 = -1;
            return;
        end
        e0 = cyc + 1;
        exp_err = (exp_err + nerr > 65535) ? 65535 : exp_err + nerr;
        e.data = exp_d;
        e.err  = exp_err[15:0];
        e.e0   = e0;
        q.push_back(e);
        e.data = d;
        e.err  = 16'h0;
        q2.push_back(e);
        @(negedge clk);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() > 0 || q2.size() > 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", (q.size() > 0 || q2.size() > 0), 0);
    endtask

    initial begin
        int e0a, e0b, e0c;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        noise    = 8'sd0;
        noise2   = 7'sd63;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sym_obs", sym_obs, 0);
        chk("rst_err", err_count, 0);
        chk("rst_sym_obs2", sym_obs2, 0);

        // 1: clean channel; beat 0 = 4'hC -> lanes -64,-64,+64,+64
        send(12'hA5C, 12'hA5C, 0, 0, e0a);
        @(negedge clk);
        chk("t1_sym_obs", sym_obs, {9'h040, 9'h040, 9'h1C0, 9'h1C0});
        chk("t1_sym_obs2_sat", sym_obs2, {8'h7F, 8'h7F, 8'hC0, 8'hC0});
        drain();

        // 2: noise pulls +64 exactly to 0, which slices as 1
        noise = -8'sd64;
        send(12'hFFF, 12'hFFF, 0, 0, e0a);
        @(negedge clk);
        chk("t2_sym_obs_zero", sym_obs, 36'h0);
        chk("t2_sym_obs2", sym_obs2, {4{8'h7F}});
        drain();

        // 3: noise one past zero flips every 1; zeros stay zero
        noise = -8'sd65;
        send(12'hFFF, 12'h000, 12, 0, e0a);
        @(negedge clk);
        chk("t3_sym_obs", sym_obs, {4{9'h1FF}});
        drain();
        send(12'h000, 12'h000, 0, 0, e0a);
        @(negedge clk);
        chk("t3b_sym_obs", sym_obs, {4{9'h17F}});
        drain();

        // 5: in_valid held high across three words
        noise = 8'sd0;
        send(12'h3C1, 12'h3C1, 0, 1, e0a);
        send(12'h7E2, 12'h7E2, 0, 1, e0b);
        send(12'h058, 12'h058, 0, 0, e0c);
        chk("t5_spacing_ab", e0b - e0a, 3);
        chk("t5_spacing_bc", e0c - e0b, 3);
        drain();

        // Error counter saturation: 12 errors per word until it pins at FFFF
        noise = -8'sd65;
        for (int i = 0; i < 5465; i++) begin
            send(12'hFFF, 12'h000, 12, 1, e0a);
        end
        in_valid = 1'b0;
        drain();
        chk("err_saturated", err_count, 16'hFFFF);

        // 6: reset during beat 1, with a competing handshake on the same edge
        noise = 8'sd0;
        send(12'h123, 12'h123, 0, 0, e0a);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 12'h789;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        q2.delete();
        exp_err = 0;
        chk("t6_in_ready", in_ready, 1);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_err", err_count, 0);
        chk("t6_out_data", out_data, 0);
        repeat (6) @(negedge clk);
        send(12'h456, 12'h456, 0, 0, e0a);
        drain();
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
